// File: rtl/issue_fifo.sv
// issue_fifo: in-order issue queue between decode/dispatch and register-read.
// Circular buffer of DEPTH x WIDTH entries with a show-ahead output (oldest entry on dout),
// occupancy flags for fetch stalling and a flush input for redirect squashes.
// Optional build macro ISSUE_FIFO_BYPASS_EN: when the queue is empty, a pushed entry is
// presented on dout in the same cycle and, if popped in that cycle, never written.

module issue_fifo #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_front,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop_back,
    output logic [WIDTH-1:0]           dout,
    output logic                       ready,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;

    logic push_acc;
    logic pop_acc;
    logic bypass_take;
    logic wr_en;

    // Flags come from registered occupancy only.
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CntW'(DEPTH));
        almost_full = (count_q >= CntW'(AFULL_THRESH));
        count       = count_q;
    end

    // Accept decisions; a push into a full queue only succeeds alongside a pop.
    always_comb begin
        push_acc    = push_front & (~full | pop_back);
        pop_acc     = pop_back & ~empty;
`ifdef ISSUE_FIFO_BYPASS_EN
        // Empty queue, push and pop together: entry flows straight through, nothing stored.
        bypass_take = empty & push_front & pop_back & ~flush;
`else
        bypass_take = 1'b0;
`endif
        wr_en       = push_acc & ~bypass_take & ~flush;
    end

    // Next-state for pointers and occupancy; flush squashes everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (!bypass_take) begin
            if (push_acc) begin
                tail_d = tail_q + PtrW'(1);
            end
            if (pop_acc) begin
                head_d = head_q + PtrW'(1);
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CntW'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; deliberately not reset since contents are qualified by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= din;
        end
    end

    // Show-ahead output: oldest entry, or zero when nothing is valid.
    always_comb begin
        dout  = empty ? '0 : mem_q[head_q];
        ready = ~empty;
`ifdef ISSUE_FIFO_BYPASS_EN
        if (empty && push_front && !flush) begin
            dout  = din;
            ready = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_issue_fifo.sv
// Directed self-checking bench for issue_fifo (DEPTH=4, WIDTH=32, AFULL_THRESH=3).

module tb_issue_fifo;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_front;
    logic [31:0] din;
    logic        pop_back;
    logic [31:0] dout;
    logic        ready;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [2:0]  count;

    int n_cmp;
    int n_err;

    issue_fifo #(
        .WIDTH        (32),
        .DEPTH        (4),
        .AFULL_THRESH (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push_front  (push_front),
        .din         (din),
        .pop_back    (pop_back),
        .dout        (dout),
        .ready       (ready),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        push_front = 1'b0;
        pop_back   = 1'b0;
        din        = '0;
    endtask

    logic [31:0] exp_pop [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset / idle state
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_afull", 32'(almost_full), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_dout", dout, 32'h0);

        // Fill with A0..A3
        for (int i = 0; i < 4; i++) begin
            push_front = 1'b1;
            din        = 32'hA0 + 32'(i);
            tick();
            check_val("fill_count", 32'(count), 32'(i + 1));
            check_val("fill_afull", 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
            check_val("fill_full", 32'(full), (i + 1 == 4) ? 32'd1 : 32'd0);
            check_val("fill_dout", dout, 32'hA0);
        end

        // Fifth push while full without pop is dropped
        din = 32'hA4;
        tick();
        check_val("drop_count", 32'(count), 32'd4);
        check_val("drop_dout", dout, 32'hA0);

        // Push+pop from full for six cycles, crossing the pointer wrap
        exp_pop[0] = 32'hA0;
        exp_pop[1] = 32'hA1;
        exp_pop[2] = 32'hA2;
        exp_pop[3] = 32'hA3;
        exp_pop[4] = 32'hB0;
        exp_pop[5] = 32'hB1;
        for (int i = 0; i < 6; i++) begin
            push_front = 1'b1;
            pop_back   = 1'b1;
            din        = 32'hB0 + 32'(i);
            #1;
            check_val("pp_dout", dout, exp_pop[i]);
            tick();
            check_val("pp_count", 32'(count), 32'd4);
        end

        // Drain remaining B2..B5
        push_front = 1'b0;
        pop_back   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("drain_dout", dout, 32'hB2 + 32'(i));
            tick();
            check_val("drain_count", 32'(count), 32'(3 - i));
        end
        check_val("drain_empty", 32'(empty), 32'd1);
        check_val("drain_dout0", dout, 32'h0);
        tick();
        check_val("pop_empty_count", 32'(count), 32'd0);
        check_val("pop_empty_empty", 32'(empty), 32'd1);

        // Hold three entries, then flush with simultaneous push and pop
        pop_back   = 1'b0;
        push_front = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 32'hE0 + 32'(i);
            tick();
        end
        check_val("pre_flush_count", 32'(count), 32'd3);
        flush      = 1'b1;
        push_front = 1'b1;
        pop_back   = 1'b1;
        din        = 32'hC0;
        tick();
        flush    = 1'b0;
        pop_back = 1'b0;
        check_val("flush_count", 32'(count), 32'd0);
        check_val("flush_empty", 32'(empty), 32'd1);
        check_val("flush_dout", dout, 32'h0);
        din = 32'hC1;
        tick();
        check_val("post_flush_dout", dout, 32'hC1);
        check_val("post_flush_count", 32'(count), 32'd1);
        check_val("post_flush_ready", 32'(ready), 32'd1);

        // count==1 with push and pop: new entry becomes head
        pop_back = 1'b1;
        din      = 32'hC2;
        tick();
        check_val("one_pp_count", 32'(count), 32'd1);
        check_val("one_pp_dout", dout, 32'hC2);

        // Empty the queue, then push+pop together while empty
        push_front = 1'b0;
        tick();
        check_val("empty_again", 32'(empty), 32'd1);
        push_front = 1'b1;
        pop_back   = 1'b1;
        din        = 32'hD0;
        #1;
`ifdef ISSUE_FIFO_BYPASS_EN
        check_val("byp_dout", dout, 32'hD0);
        check_val("byp_ready", 32'(ready), 32'd1);
        check_val("byp_empty", 32'(empty), 32'd1);
        tick();
        idle_inputs();
        #1;
        check_val("byp_count", 32'(count), 32'd0);
        check_val("byp_after_empty", 32'(empty), 32'd1);
`else
        check_val("nobyp_ready", 32'(ready), 32'd0);
        check_val("nobyp_dout", dout, 32'h0);
        tick();
        idle_inputs();
        #1;
        check_val("nobyp_count", 32'(count), 32'd1);
        check_val("nobyp_head", dout, 32'hD0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_fifo.md
Name: issue_fifo

Overview:
- Parametrised in-order issue queue replacing the single-entry dispatch queue between decode/dispatch and register-read.
- Circular buffer of DEPTH entries, WIDTH bits each, with show-ahead output: the oldest entry is always presented on dout.
- Provides full, empty, occupancy count and almost_full for fetch stalling.
- Provides a flush input to squash all entries on a decode or execute redirect.

Parameters:
- WIDTH, 32: entry width in bits (the packed queue item).
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- AFULL_THRESH, DEPTH-1: almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all entries (redirect squash).
- push_front  in  1  enqueue request.
- din  in  WIDTH  entry to enqueue.
- pop_back  in  1  dequeue request for the oldest entry.
- dout  out  WIDTH  oldest entry; '0 when empty.
- ready  out  1  dout is valid; equals ~empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Storage:
  - DEPTH x WIDTH register array; the array itself is not reset.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is registered.
- Reset (rst=1 at an edge): head=0, tail=0, count=0.
  - Outputs after reset: empty=1, ready=0, full=0, almost_full=0, count=0, dout='0.
- Flush (flush=1 at an edge, rst=0):
  - Same pointer and count result as reset.
  - Overrides push_front and pop_back in the same cycle; din is not stored.
- Accept rules:
  - push_acc = push_front & (~full | pop_back).
  - pop_acc = pop_back & ~empty.
  - Push while full is accepted only when pop_back is asserted in the same cycle.
  - Push while full without pop is dropped; no state change.
  - Pop while empty is ignored.
- On push_acc: mem[tail] <= din; tail <= tail+1.
- On pop_acc: head <= head+1.
- count update:
  - +1 on push_acc only.
  - -1 on pop_acc only.
  - Unchanged when both or neither are accepted.
- dout = mem[head] when ~empty, else '0. It is combinational from registered state.
- Latency: an entry pushed at edge N appears on dout after edge N; it is poppable in cycle N+1.
- Flags are derived combinationally from registered count; no flag depends on push_front, pop_back or flush in the same cycle.
- Ordering: strict FIFO, with no reordering across pointer wrap.
- Simultaneous push and pop with count==1: the old head is consumed and the new entry becomes head; count stays 1.

Optional Feature:
- Macro: ISSUE_FIFO_BYPASS_EN.
- Defined:
  - When empty & push_front & ~flush, dout=din and ready=1 combinationally in the same cycle.
  - If pop_back is also asserted, the entry is consumed without being written: pointers and count are unchanged.
  - If pop_back is low, the entry is written normally.
  - empty, count and full still reflect registered state only.
- Not defined:
  - No bypass; an entry is visible one cycle after its push.
  - pop_back while empty is ignored even if push_front is high.

Test Plan:
- Reset then idle -> empty=1, ready=0, full=0, count=0, dout=0.
- DEPTH=4: push 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, no pop -> count 1,2,3,4; almost_full=1 at count 3; full=1 at count 4; dout=0xA0 throughout. A fifth push of 0xA4 without pop is dropped, count stays 4.
- From full, assert push 0xB0 and pop together for 6 cycles -> count stays 4. Popped sequence is 0xA0..0xA3 then 0xB0, 0xB1, which exercises pointer wrap.
- Drain 4 pops -> empty=1 and dout=0 after the last pop. A 5th pop is ignored and count stays 0.
- Hold 3 entries, assert flush with push 0xC0 and pop in the same cycle -> next cycle count=0, empty=1. A following push of 0xC1 appears as head.
- Bypass (macro defined): empty, push 0xD0 with pop in the same cycle -> dout=0xD0 that cycle; count stays 0 afterwards. Without the macro, ready=0 that cycle and count=1 afterwards.
